// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
//
// Scans an 8-digit, common-anode, multiplexed seven-segment display showing
// one of four 32-bit CPU words as hexadecimal. A debounced push-button steps
// the selected source. The displayed word is captured once per scan frame, so
// all eight digits always show one coherent value.
//
// Parameters
//   SCAN_DIV   : clk cycles each digit stays lit (>= 2)
//   DEB_CYCLES : consecutive stable cycles needed to accept a button change (>= 1)
//   BLANK_LZ   : 1 = blank leading zero digits (digit 0 always shown)
//
// Ports
//   clk          in   system clock
//   clr          in   asynchronous active-high reset
//   Leddata      in   source 0
//   Count_all    in   source 1
//   Count_branch in   source 2
//   Count_jmp    in   source 3
//   btn_mode     in   raw bouncing mode button, active-high
//   AN[7:0]      out  digit enables, active-low, AN[0] = rightmost digit
//   SEG[7:0]     out  segments {dp,g,f,e,d,c,b,a}, active-low
//   mode[1:0]    out  selected source index; dp is lit on digit == mode
// -----------------------------------------------------------------------------
module seg7_scan_display #(
   parameter int SCAN_DIV   = 100000,
   parameter int DEB_CYCLES = 1000000,
   parameter int BLANK_LZ   = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] Leddata,
   input  logic [31:0] Count_all,
   input  logic [31:0] Count_branch,
   input  logic [31:0] Count_jmp,
   input  logic        btn_mode,
   output logic [7:0]  AN,
   output logic [7:0]  SEG,
   output logic [1:0]  mode
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   // A one-cycle debounce still needs a 1-bit counter to stay legal.
   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [DIV_W-1:0] div_cnt_reg;
   logic [2:0]       digit_reg;
   logic [31:0]      shadow_reg;
   logic [1:0]       mode_reg;
   logic [1:0]       sync_reg;
   logic             deb_level_reg;
   logic [DEB_W-1:0] deb_cnt_reg;

   logic             tick;
   logic             btn_s;
   logic [31:0]      src_word;

   assign tick  = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));
   assign btn_s = sync_reg[1];

   // ---------------------------------------------------------------- scan
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div_cnt_reg <= '0;
         digit_reg   <= '0;
      end else if (tick) begin
         div_cnt_reg <= '0;
         digit_reg   <= digit_reg + 3'd1;
      end else begin
         div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
   end

   // ------------------------------------------------------------ snapshot
   always_comb begin
      src_word = Leddata;
      case (mode_reg)
         2'd0: src_word = Leddata;
         2'd1: src_word = Count_all;
         2'd2: src_word = Count_branch;
         2'd3: src_word = Count_jmp;
         default: src_word = Leddata;
      endcase
   end

   // The word is reloaded only as digit 7 hands over to digit 0, so a
   // frame never mixes nibbles from two different source values.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         shadow_reg <= '0;
      end else if (tick && digit_reg == 3'd7) begin
         shadow_reg <= src_word;
      end
   end

   // ------------------------------------------------ button sync/debounce
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_reg      <= '0;
         deb_level_reg <= 1'b0;
         deb_cnt_reg   <= '0;
         mode_reg      <= '0;
      end else begin
         sync_reg <= {sync_reg[0], btn_mode};
         if (btn_s != deb_level_reg) begin
            // Accept the new level after DEB_CYCLES consecutive mismatches;
            // any return to the old level clears the count below.
            if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
               deb_level_reg <= btn_s;
               deb_cnt_reg   <= '0;
               if (btn_s) begin
                  mode_reg <= mode_reg + 2'd1;
               end
            end else begin
               deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
         end else begin
            deb_cnt_reg <= '0;
         end
      end
   end

   assign mode = mode_reg;

   // -------------------------------------------------------------- decode
   logic [3:0] nib [8];
   logic [7:0] upper_zero;

   // upper_zero[i]: every nibble from digit i upward is zero, i.e. digit i
   // is a leading zero. Digit 0 is never treated as one.
   for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign nib[gi] = shadow_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
         assign upper_zero[gi] = 1'b0;
      end else begin : g_upper
         assign upper_zero[gi] = (shadow_reg[31:4*gi] == '0);
      end
   end

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   logic [6:0] seg_dec;

   always_comb begin
      seg_dec = hex7(nib[digit_reg]);
      if (BLANK_LZ != 0 && upper_zero[digit_reg]) begin
         seg_dec = 7'h7F;
      end
   end

   assign AN  = ~(8'h01 << digit_reg);
   // dp marks the selected source and ignores blanking.
   assign SEG = {(digit_reg != {1'b0, mode_reg}), seg_dec};

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

   localparam int SD  = 4;
   localparam int DEB = 3;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] Leddata = '0, Count_all = '0, Count_branch = '0, Count_jmp = '0;
   logic        btn_mode = 1'b0;
   logic [7:0]  AN, SEG, AN_nb, SEG_nb;
   logic [1:0]  mode, mode_nb;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   seg7_scan_display #(.SCAN_DIV(SD), .DEB_CYCLES(DEB), .BLANK_LZ(1)) u_dut (
      .clk(clk), .clr(clr), .Leddata(Leddata), .Count_all(Count_all),
      .Count_branch(Count_branch), .Count_jmp(Count_jmp), .btn_mode(btn_mode),
      .AN(AN), .SEG(SEG), .mode(mode));

   seg7_scan_display #(.SCAN_DIV(SD), .DEB_CYCLES(DEB), .BLANK_LZ(0)) u_dut_nb (
      .clk(clk), .clr(clr), .Leddata(Leddata), .Count_all(Count_all),
      .Count_branch(Count_branch), .Count_jmp(Count_jmp), .btn_mode(btn_mode),
      .AN(AN_nb), .SEG(SEG_nb), .mode(mode_nb));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------ reference model
   // Time-based view: after reset release the display position is purely
   // a function of the number of clock edges, the word is captured every
   // 8*SD edges, and the button is a 2-cycle delayed level that must
   // disagree with the accepted level for DEB edges in a row.
   logic [6:0] hex_tbl [16];
   initial begin
      hex_tbl[0]  = 7'h40; hex_tbl[1]  = 7'h79; hex_tbl[2]  = 7'h24; hex_tbl[3]  = 7'h30;
      hex_tbl[4]  = 7'h19; hex_tbl[5]  = 7'h12; hex_tbl[6]  = 7'h02; hex_tbl[7]  = 7'h78;
      hex_tbl[8]  = 7'h00; hex_tbl[9]  = 7'h10; hex_tbl[10] = 7'h08; hex_tbl[11] = 7'h03;
      hex_tbl[12] = 7'h46; hex_tbl[13] = 7'h21; hex_tbl[14] = 7'h06; hex_tbl[15] = 7'h0E;
   end

   int          m_edges;
   logic [31:0] m_shadow;
   int          m_mode;
   bit          m_s1, m_bs, m_lvl;
   int          m_run;

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m_edges = 0; m_shadow = 0; m_mode = 0;
         m_s1 = 0; m_bs = 0; m_lvl = 0; m_run = 0;
      end else begin
         m_edges++;
         if (m_edges % (8 * SD) == 0) begin
            case (m_mode)
               0: m_shadow = Leddata;
               1: m_shadow = Count_all;
               2: m_shadow = Count_branch;
               default: m_shadow = Count_jmp;
            endcase
         end
         if (m_bs != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
               m_lvl = m_bs;
               m_run = 0;
               if (m_bs) m_mode = (m_mode + 1) % 4;
            end
         end else begin
            m_run = 0;
         end
         m_bs = m_s1;
         m_s1 = btn_mode;
      end
   end

   function automatic logic [7:0] exp_seg(input logic [31:0] sh, input int d, input int md, input bit blank_lz);
      logic [31:0] upper;
      logic [6:0]  s;
      upper = sh >> (4 * d);
      s = hex_tbl[upper[3:0]];
      if (blank_lz && d != 0 && upper == 0) s = 7'h7F;
      return {(d == md) ? 1'b0 : 1'b1, s};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         int d;
         logic [7:0] an_exp;
         d = (m_edges / SD) % 8;
         an_exp = 8'hFF ^ (8'h01 << d);
         check_val("an", AN, an_exp);
         check_val("seg", SEG, exp_seg(m_shadow, d, m_mode, 1'b1));
         check_val("mode", mode, m_mode);
         check_val("an_nb", AN_nb, an_exp);
         check_val("seg_nb", SEG_nb, exp_seg(m_shadow, d, m_mode, 1'b0));
      end
   end

   // ------------------------------------------------ stimulus helpers
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the first negedge of a fresh slot for digit d.
   task automatic wait_digit(input int d);
      logic [7:0] tgt;
      int k;
      tgt = 8'hFF ^ (8'h01 << d);
      k = 0;
      while (AN == tgt && k < 100) begin @(negedge clk); k++; end
      while (AN != tgt && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) check_val("wait_digit_timeout", 32'(AN), 32'(tgt));
   endtask

   task automatic press(input int hold, input int rel);
      btn_mode = 1'b1; cycles(hold);
      btn_mode = 1'b0; cycles(rel);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 clr = 1'b1;
      #1;
      check_val("rst_an", AN, 8'hFE);
      check_val("rst_seg", SEG, 8'h40);
      check_val("rst_mode", mode, 2'd0);
      check_val("rst_seg_nb", SEG_nb, 8'h40);
      @(negedge clk);
      clr = 1'b0;
   endtask

   function automatic logic [31:0] rnd_word();
      logic [63:0] v;
      int k;
      k = $urandom_range(0, 8);
      v = {32'h0, $urandom()} & ((64'h1 << (4 * k)) - 64'h1);
      return v[31:0];
   endfunction

   // ------------------------------------------------ main sequence
   initial begin
      #2;
      check_val("init_an", AN, 8'hFE);
      check_val("init_seg", SEG, 8'h40);
      check_val("init_mode", mode, 2'd0);
      @(negedge clk);
      clr = 1'b0;
      chk_en = 1'b1;

      // Scan timing after release
      cycles(3);  check_val("scan_d0", AN, 8'hFE);
      cycles(1);  check_val("scan_d1", AN, 8'hFD);
      cycles(27); check_val("scan_d7", AN, 8'h7F);
      cycles(1);  check_val("scan_wrap", AN, 8'hFE);
      $display("txn scan timing");

      // 0000_12AF with leading-zero blanking
      Leddata = 32'h0000_12AF;
      cycles(40);
      wait_digit(0); check_val("12af_d0", SEG, 8'h0E);
      wait_digit(1); check_val("12af_d1", SEG, 8'h88);
      wait_digit(2); check_val("12af_d2", SEG, 8'hA4);
      wait_digit(3); check_val("12af_d3", SEG, 8'hF9);
      wait_digit(4); check_val("12af_d4", SEG, 8'hFF);
      wait_digit(7); check_val("12af_d7", SEG, 8'hFF);
      $display("txn Leddata=%h", Leddata);

      // All zero: blanked vs unblanked
      Leddata = 32'h0;
      cycles(40);
      wait_digit(0); check_val("zero_d0", SEG, 8'h40); check_val("zero_d0_nb", SEG_nb, 8'h40);
      wait_digit(5); check_val("zero_d5", SEG, 8'hFF); check_val("zero_d5_nb", SEG_nb, 8'hC0);
      $display("txn Leddata=%h", Leddata);

      // Mid-frame change stays hidden until the next frame
      Leddata = 32'h1;
      cycles(40);
      wait_digit(0); check_val("mid_before", SEG, 8'h79);
      Leddata = 32'h2;
      @(negedge clk); check_val("mid_same_frame", SEG, 8'h79);
      wait_digit(0); check_val("mid_next_frame", SEG, 8'h24);
      $display("txn mid-frame change 1->2");

      // Bounce must not advance mode; a clean hold advances it once
      btn_mode = 1; cycles(1); btn_mode = 0; cycles(1); btn_mode = 1; cycles(1); btn_mode = 0;
      cycles(10); check_val("bounce_mode", mode, 2'd0);
      Count_all = 32'h0000_00C3;
      btn_mode = 1; cycles(10); check_val("hold_mode", mode, 2'd1);
      btn_mode = 0; cycles(10); check_val("release_mode", mode, 2'd1);
      cycles(40);
      wait_digit(1); check_val("count_all_d1_dp", SEG, 8'h46);
      $display("txn button bounce/hold mode=%0d", mode);

      // Four clean presses from reset: 1,2,3,0
      async_reset();
      press(8, 8); check_val("press1", mode, 2'd1);
      press(8, 8); check_val("press2", mode, 2'd2);
      press(8, 8); check_val("press3", mode, 2'd3);
      press(8, 8); check_val("press4", mode, 2'd0);
      Count_jmp = 32'hFFFF_FFFF;
      press(8, 8); press(8, 8); press(8, 8);
      check_val("mode3", mode, 2'd3);
      cycles(40);
      for (int d = 0; d < 8; d++) begin
         wait_digit(d);
         check_val($sformatf("jmp_d%0d", d), SEG, (d == 3) ? 8'h0E : 8'h8E);
      end
      $display("txn four presses, Count_jmp=%h", Count_jmp);

      // Randomized traffic checked continuously against the model
      for (int t = 0; t < 30; t++) begin
         int act;
         Leddata = rnd_word(); Count_all = rnd_word();
         Count_branch = rnd_word(); Count_jmp = rnd_word();
         act = $urandom_range(0, 3);
         case (act)
            1: for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
                  btn_mode = 1; cycles($urandom_range(1, 2));
                  btn_mode = 0; cycles($urandom_range(1, 2));
               end
            2: press($urandom_range(4, 12), $urandom_range(4, 12));
            3: async_reset();
            default: ;
         endcase
         cycles($urandom_range(5, 60));
         $display("txn %0d act=%0d led=%h all=%h br=%h jmp=%h mode=%0d",
                  t, act, Leddata, Count_all, Count_branch, Count_jmp, mode);
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
